// File: rtl/mask_arb.sv
// mask_arb: round-robin sharing of one wrap-aware byte-mask calculator among three requesters.
module mask_arb #(
  parameter int NB = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    req_valid,
  output logic [2:0]    req_ready,
  input  logic [3*AW-1:0] req_strt,
  input  logic [3*AW-1:0] req_end,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [1:0]    rsp_id,
  output logic [NB-1:0] rsp_mask,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  state_t state;
  logic [1:0] ptr, p1, p2, g, gid;
  logic [AW-1:0] s, e;
  logic [NB-1:0] mask_n;
  assign p1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  assign p2 = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
  assign g  = req_valid[ptr] ? ptr : req_valid[p1] ? p1 : p2;
  assign req_ready = (state == IDLE && |req_valid && !reset) ? (3'b001 << g) : 3'b000;
  assign busy = (state != IDLE);
  // s > e selects the wrap-around span covering both ends of the lane range
  always_comb begin
    mask_n = '0;
    for (int i = 0; i < NB; i++)
      mask_n[i] = (s <= e) ? (AW'(i) >= s && AW'(i) <= e) : (AW'(i) >= s || AW'(i) <= e);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gid       <= 2'd0;
      s         <= '0;
      e         <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 2'd0;
      rsp_mask  <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          s     <= req_strt[AW*g +: AW];
          e     <= req_end[AW*g +: AW];
          gid   <= g;
          ptr   <= (g == 2'd2) ? 2'd0 : g + 2'd1;
          state <= CALC;
        end
        CALC: begin
          rsp_mask  <= mask_n;
          rsp_id    <= gid;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
